memory_port_arbiter: RTL and testbench

- Shares the single unified memory bus between the instruction-fetch requester and the load/store (data) requester.
- Produces the fetch-side instructionDataValid/instructionData pair and the data-side completion pulse.
- Sits between the Fetch/Memory pipeline stages and the memory interface.
- Sequences one outstanding bus transaction at a time, prioritises data accesses, and discards fetch responses killed by a redirect.

---
 rtl/memory_port_arbiter_if.sv | 44 ++++
 rtl/memory_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the unified memory bus.
// The master modport is the arbiter's view; slave is the surrounding requesters and memory.
interface memory_port_arbiter_if;
    logic        fetchRequest;
    logic [31:0] fetchAddress;
    logic        fetchKill;
    logic        instructionDataValid;
    logic [31:0] instructionData;

    logic        dataRequest;
    logic        dataWrite;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic [3:0]  dataByteEnable;
    logic        dataReady;
    logic [31:0] dataReadData;

    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memAccept;
    logic        memResponseValid;
    logic [31:0] memReadData;

    modport master (
        input  fetchRequest, fetchAddress, fetchKill,
        output instructionDataValid, instructionData,
        input  dataRequest, dataWrite, dataAddress, dataWriteData, dataByteEnable,
        output dataReady, dataReadData,
        output memRequest, memWrite, memAddress, memWriteData, memByteEnable,
        input  memAccept, memResponseValid, memReadData
    );

    modport slave (
        output fetchRequest, fetchAddress, fetchKill,
        input  instructionDataValid, instructionData,
        output dataRequest, dataWrite, dataAddress, dataWriteData, dataByteEnable,
        input  dataReady, dataReadData,
        input  memRequest, memWrite, memAddress, memWriteData, memByteEnable,
        output memAccept, memResponseValid, memReadData
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_FAIRNESS_EN to force a waiting fetch through after MAX_DATA_STREAK data grants.
module memory_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    memory_port_arbiter_if.master  bus,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_param_check
        $error("MAX_DATA_STREAK must be in 1..15");
    end

    state_t      state_q, state_d;
    logic        owner_data_q, owner_data_d;
    logic        discard_q, discard_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ivalid_q, ivalid_d;
    logic [31:0] idata_q, idata_d;
    logic        dready_q, dready_d;
    logic [31:0] drdata_q, drdata_d;

    logic        fetch_eligible;
    logic        grant_data;
    logic        grant_fetch;

    assign fetch_eligible = bus.fetchRequest & ~bus.fetchKill;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);
    logic [3:0] streak_q, streak_d;
    logic       streak_force;

    // >= rather than == so a kill landing on the forcing cycle cannot push the count past the limit forever.
    always_comb begin
        streak_force = (streak_q >= STREAK_LIMIT) && fetch_eligible;
        grant_data   = (state_q == IDLE) && bus.dataRequest && !streak_force;
        grant_fetch  = (state_q == IDLE) && fetch_eligible && !grant_data;
        streak_d     = streak_q;
        if (grant_fetch) begin
            streak_d = 4'd0;
        end else if (grant_data) begin
            if (!bus.fetchRequest)        streak_d = 4'd0;
            else if (streak_q != 4'hF)    streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) streak_q <= 4'd0;
        else       streak_q <= streak_d;
    end
`else
    always_comb begin
        grant_data  = (state_q == IDLE) && bus.dataRequest;
        grant_fetch = (state_q == IDLE) && fetch_eligible && !bus.dataRequest;
    end
`endif

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        discard_d    = discard_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        ivalid_d     = 1'b0;
        idata_d      = idata_q;
        dready_d     = 1'b0;
        drdata_d     = drdata_q;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (grant_data) begin
                    owner_data_d = 1'b1;
                    addr_d       = bus.dataAddress;
                    write_d      = bus.dataWrite;
                    wdata_d      = bus.dataWriteData;
                    be_d         = bus.dataByteEnable;
                    state_d      = ISSUE;
                end else if (grant_fetch) begin
                    owner_data_d = 1'b0;
                    addr_d       = bus.fetchAddress;
                    write_d      = 1'b0;
                    wdata_d      = 32'd0;
                    be_d         = 4'hF;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (!owner_data_q && bus.fetchKill) discard_d = 1'b1;
                if (bus.memAccept)                  state_d   = WAIT;
            end
            WAIT: begin
                if (bus.memResponseValid) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (owner_data_q) begin
                        dready_d = 1'b1;
                        drdata_d = bus.memReadData;
                    end else if (!(discard_q || bus.fetchKill)) begin
                        ivalid_d = 1'b1;
                        idata_d  = bus.memReadData;
                    end
                end else if (!owner_data_q && bus.fetchKill) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            discard_q    <= 1'b0;
            addr_q       <= 32'd0;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            ivalid_q     <= 1'b0;
            idata_q      <= 32'd0;
            dready_q     <= 1'b0;
            drdata_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            discard_q    <= discard_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            ivalid_q     <= ivalid_d;
            idata_q      <= idata_d;
            dready_q     <= dready_d;
            drdata_q     <= drdata_d;
        end
    end

    assign bus.memRequest           = (state_q == ISSUE);
    assign bus.memWrite             = (state_q == ISSUE) && write_q;
    assign bus.memAddress           = addr_q;
    assign bus.memWriteData         = wdata_q;
    assign bus.memByteEnable        = be_q;
    assign bus.instructionDataValid = ivalid_q;
    assign bus.instructionData      = idata_q;
    assign bus.dataReady            = dready_q;
    assign bus.dataReadData         = drdata_q;
    assign busy                     = (state_q != IDLE);
endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: fetch/data sequencing, kill, stalls, fairness, async reset.
module tb_memory_port_arbiter;
    logic clock;
    logic reset;
    logic busy;
    int   checks_total;
    int   checks_passed;

    memory_port_arbiter_if bus();

    memory_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (!reset && bus.instructionDataValid)
            $display("txn fetch complete data=%h", bus.instructionData);
        if (!reset && bus.dataReady)
            $display("txn data complete rdata=%h", bus.dataReadData);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Assumes memRequest is visible now; on return the completion pulse is visible.
    task automatic serve(input int acc_wait, input int rsp_wait, input logic [31:0] rd);
        repeat (acc_wait) tick();
        bus.memAccept = 1'b1;
        tick();
        bus.memAccept = 1'b0;
        repeat (rsp_wait) tick();
        bus.memResponseValid = 1'b1;
        bus.memReadData      = rd;
        tick();
        bus.memResponseValid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks_total++;
        if ({busy, bus.memRequest, bus.memWrite, bus.instructionDataValid, bus.dataReady} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, bus.memRequest, bus.memWrite, bus.instructionDataValid, bus.dataReady});
        else checks_passed++;
        checks_total++;
        if ({bus.memAddress, bus.memWriteData, bus.memByteEnable} !== 68'd0)
            $display("FAIL reset_fields: got addr=%h wd=%h be=%h want 0",
                     bus.memAddress, bus.memWriteData, bus.memByteEnable);
        else checks_passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lone_fetch();
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h100;
        tick();
        checks_total++;
        if ({busy, bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable} !== {3'b110, 32'h100, 4'hF})
            $display("FAIL lone_issue: got req=%b wr=%b addr=%h be=%h want 1 0 100 f",
                     bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable);
        else checks_passed++;
        bus.memAccept = 1'b1;
        tick();
        bus.memAccept = 1'b0;
        checks_total++;
        if ({busy, bus.memRequest} !== 2'b10)
            $display("FAIL lone_wait: got busy=%b req=%b want 1 0", busy, bus.memRequest);
        else checks_passed++;
        tick();
        bus.memResponseValid = 1'b1;
        bus.memReadData      = 32'h00500093;
        tick();
        bus.memResponseValid = 1'b0;
        checks_total++;
        if ({bus.instructionDataValid, bus.instructionData, busy, bus.dataReady} !== {1'b1, 32'h00500093, 2'b00})
            $display("FAIL lone_pulse: got v=%b d=%h busy=%b dr=%b want 1 00500093 0 0",
                     bus.instructionDataValid, bus.instructionData, busy, bus.dataReady);
        else checks_passed++;
        bus.fetchRequest = 1'b0;
        tick();
        checks_total++;
        if ({bus.instructionDataValid, busy, bus.memRequest} !== 3'b000)
            $display("FAIL lone_single_pulse: got v=%b busy=%b req=%b want 000",
                     bus.instructionDataValid, busy, bus.memRequest);
        else checks_passed++;
    endtask

    task automatic test_simultaneous();
        bus.fetchRequest   = 1'b1;
        bus.fetchAddress   = 32'h400;
        bus.dataRequest    = 1'b1;
        bus.dataWrite      = 1'b1;
        bus.dataAddress    = 32'h2000;
        bus.dataWriteData  = 32'hDEADBEEF;
        bus.dataByteEnable = 4'b0011;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memWrite, bus.memAddress, bus.memWriteData, bus.memByteEnable}
                !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'b0011})
            $display("FAIL simul_data_first: got req=%b wr=%b addr=%h wd=%h be=%b want 1 1 2000 deadbeef 0011",
                     bus.memRequest, bus.memWrite, bus.memAddress, bus.memWriteData, bus.memByteEnable);
        else checks_passed++;
        serve(0, 0, 32'h0);
        checks_total++;
        if ({bus.dataReady, bus.instructionDataValid} !== 2'b10)
            $display("FAIL simul_store_done: got dr=%b iv=%b want 1 0", bus.dataReady, bus.instructionDataValid);
        else checks_passed++;
        bus.dataRequest = 1'b0;
        bus.dataWrite   = 1'b0;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable} !== {2'b10, 32'h400, 4'hF})
            $display("FAIL simul_fetch_second: got req=%b wr=%b addr=%h be=%h want 1 0 400 f",
                     bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable);
        else checks_passed++;
        serve(0, 1, 32'h12345678);
        checks_total++;
        if ({bus.instructionDataValid, bus.instructionData} !== {1'b1, 32'h12345678})
            $display("FAIL simul_fetch_done: got v=%b d=%h want 1 12345678",
                     bus.instructionDataValid, bus.instructionData);
        else checks_passed++;
        bus.fetchRequest = 1'b0;
        tick();
    endtask

    task automatic test_kill();
        // kill while waiting for the response
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h200;
        tick();
        bus.memAccept = 1'b1;
        tick();
        bus.memAccept    = 1'b0;
        bus.fetchKill    = 1'b1;
        bus.fetchRequest = 1'b0;
        tick();
        bus.fetchKill = 1'b0;
        tick();
        bus.memResponseValid = 1'b1;
        bus.memReadData      = 32'h00000BAD;
        tick();
        bus.memResponseValid = 1'b0;
        checks_total++;
        if ({bus.instructionDataValid, busy} !== 2'b00)
            $display("FAIL kill_wait_discard: got v=%b busy=%b want 0 0", bus.instructionDataValid, busy);
        else checks_passed++;
        tick();
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h300;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memAddress} !== {1'b1, 32'h300})
            $display("FAIL kill_next_issue: got req=%b addr=%h want 1 300", bus.memRequest, bus.memAddress);
        else checks_passed++;
        serve(0, 0, 32'h0000AAAA);
        checks_total++;
        if ({bus.instructionDataValid, bus.instructionData} !== {1'b1, 32'h0000AAAA})
            $display("FAIL kill_next_done: got v=%b d=%h want 1 0000aaaa",
                     bus.instructionDataValid, bus.instructionData);
        else checks_passed++;
        // kill in the same cycle as the response
        bus.fetchAddress = 32'h500;
        tick();
        bus.memAccept = 1'b1;
        tick();
        bus.memAccept        = 1'b0;
        bus.memResponseValid = 1'b1;
        bus.memReadData      = 32'h55555555;
        bus.fetchKill        = 1'b1;
        bus.fetchRequest     = 1'b0;
        tick();
        bus.memResponseValid = 1'b0;
        bus.fetchKill        = 1'b0;
        checks_total++;
        if (bus.instructionDataValid !== 1'b0)
            $display("FAIL kill_with_response: got v=%b want 0", bus.instructionDataValid);
        else checks_passed++;
        // kill and new request together in IDLE: no grant this cycle
        bus.fetchRequest = 1'b1;
        bus.fetchKill    = 1'b1;
        bus.fetchAddress = 32'h600;
        tick();
        checks_total++;
        if ({bus.memRequest, busy} !== 2'b00)
            $display("FAIL kill_idle_block: got req=%b busy=%b want 0 0", bus.memRequest, busy);
        else checks_passed++;
        bus.fetchKill    = 1'b0;
        bus.fetchAddress = 32'h604;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memAddress} !== {1'b1, 32'h604})
            $display("FAIL kill_idle_regrant: got req=%b addr=%h want 1 604", bus.memRequest, bus.memAddress);
        else checks_passed++;
        serve(1, 0, 32'h06040604);
        checks_total++;
        if ({bus.instructionDataValid, bus.instructionData} !== {1'b1, 32'h06040604})
            $display("FAIL kill_idle_done: got v=%b d=%h want 1 06040604",
                     bus.instructionDataValid, bus.instructionData);
        else checks_passed++;
        bus.fetchRequest = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h700;
        tick();
        bus.dataRequest    = 1'b1;
        bus.dataWrite      = 1'b1;
        bus.dataAddress    = 32'h3004;
        bus.dataWriteData  = 32'h00000011;
        bus.dataByteEnable = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks_total++;
            if ({bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable,
                 bus.instructionDataValid, bus.dataReady} !== {2'b10, 32'h700, 4'hF, 2'b00})
                $display("FAIL stall_hold_%0d: got req=%b wr=%b addr=%h be=%h iv=%b dr=%b want 1 0 700 f 0 0", i,
                         bus.memRequest, bus.memWrite, bus.memAddress, bus.memByteEnable,
                         bus.instructionDataValid, bus.dataReady);
            else checks_passed++;
        end
        serve(0, 0, 32'h77777777);
        checks_total++;
        if ({bus.instructionDataValid, bus.instructionData, bus.dataReady} !== {1'b1, 32'h77777777, 1'b0})
            $display("FAIL stall_one_done: got iv=%b d=%h dr=%b want 1 77777777 0",
                     bus.instructionDataValid, bus.instructionData, bus.dataReady);
        else checks_passed++;
        bus.fetchRequest = 1'b0;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memWrite, bus.memAddress, bus.instructionDataValid} !== {2'b11, 32'h3004, 1'b0})
            $display("FAIL stall_data_after: got req=%b wr=%b addr=%h iv=%b want 1 1 3004 0",
                     bus.memRequest, bus.memWrite, bus.memAddress, bus.instructionDataValid);
        else checks_passed++;
        serve(0, 0, 32'h0);
        checks_total++;
        if (bus.dataReady !== 1'b1)
            $display("FAIL stall_data_done: got dr=%b want 1", bus.dataReady);
        else checks_passed++;
        bus.dataRequest = 1'b0;
        bus.dataWrite   = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        logic got_fetch;
        logic want_fetch;
        bus.fetchRequest   = 1'b1;
        bus.fetchAddress   = 32'h800;
        bus.dataRequest    = 1'b1;
        bus.dataWrite      = 1'b0;
        bus.dataAddress    = 32'h4000;
        bus.dataByteEnable = 4'hF;
        tick();
        for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FAIRNESS_EN
            want_fetch = (g == 4);
`else
            want_fetch = 1'b0;
`endif
            got_fetch = (bus.memAddress == 32'h800);
            checks_total++;
            if ({bus.memRequest, got_fetch} !== {1'b1, want_fetch})
                $display("FAIL fairness_grant_%0d: got req=%b fetch=%b want 1 %b",
                         g, bus.memRequest, got_fetch, want_fetch);
            else checks_passed++;
            serve(0, 0, 32'h00C0FFEE + 32'(g));
            if (got_fetch) bus.fetchRequest = 1'b0;
            if (g == 5) begin
                bus.dataRequest  = 1'b0;
                bus.fetchRequest = 1'b0;
            end
            tick();
        end
        checks_total++;
        if (busy !== 1'b0)
            $display("FAIL fairness_drain: got busy=%b want 0", busy);
        else checks_passed++;
    endtask

    task automatic test_reset_in_wait();
        bus.fetchRequest = 1'b1;
        bus.fetchAddress = 32'h900;
        tick();
        bus.memAccept = 1'b1;
        tick();
        bus.memAccept    = 1'b0;
        bus.fetchRequest = 1'b0;
        reset = 1'b1;
        #1;
        checks_total++;
        if ({busy, bus.memRequest, bus.memAddress, bus.memByteEnable} !== 38'd0)
            $display("FAIL async_reset_immediate: got busy=%b req=%b addr=%h be=%h want 0",
                     busy, bus.memRequest, bus.memAddress, bus.memByteEnable);
        else checks_passed++;
        tick();
        reset = 1'b0;
        bus.memResponseValid = 1'b1;
        bus.memReadData      = 32'hFFFFFFFF;
        tick();
        bus.memResponseValid = 1'b0;
        checks_total++;
        if ({bus.instructionDataValid, bus.dataReady, busy} !== 3'b000)
            $display("FAIL stray_response: got iv=%b dr=%b busy=%b want 000",
                     bus.instructionDataValid, bus.dataReady, busy);
        else checks_passed++;
        bus.dataRequest = 1'b1;
        bus.dataWrite   = 1'b0;
        bus.dataAddress = 32'hA00;
        tick();
        checks_total++;
        if ({bus.memRequest, bus.memWrite, bus.memAddress} !== {2'b10, 32'hA00})
            $display("FAIL post_reset_issue: got req=%b wr=%b addr=%h want 1 0 a00",
                     bus.memRequest, bus.memWrite, bus.memAddress);
        else checks_passed++;
        serve(0, 0, 32'hCAFEF00D);
        checks_total++;
        if ({bus.dataReady, bus.dataReadData} !== {1'b1, 32'hCAFEF00D})
            $display("FAIL post_reset_load: got dr=%b rd=%h want 1 cafef00d", bus.dataReady, bus.dataReadData);
        else checks_passed++;
        bus.dataRequest = 1'b0;
        tick();
    endtask

    initial begin
        checks_total         = 0;
        checks_passed        = 0;
        reset                = 1'b1;
        bus.fetchRequest     = 1'b0;
        bus.fetchAddress     = 32'd0;
        bus.fetchKill        = 1'b0;
        bus.dataRequest      = 1'b0;
        bus.dataWrite        = 1'b0;
        bus.dataAddress      = 32'd0;
        bus.dataWriteData    = 32'd0;
        bus.dataByteEnable   = 4'd0;
        bus.memAccept        = 1'b0;
        bus.memResponseValid = 1'b0;
        bus.memReadData      = 32'd0;

        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_kill();
        test_stall();
        test_fairness();
        test_reset_in_wait();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
